// File: rtl/chunk_rotate_register.sv
// Register with chunk-granular commands: rotate (one chunk per clock), low-chunk write,
// full load, shift-insert and clear, behind a valid/ready command handshake.
module chunk_rotate_register #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16,
    parameter int NCH   = WIDTH / CHUNK,
    parameter int AW    = $clog2(NCH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_op_i,
    input  logic [AW-1:0]    cmd_amt_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic {IDLE, ROTATE} state_t;

    localparam logic [2:0] OP_ROTL   = 3'b001;
    localparam logic [2:0] OP_ROTR   = 3'b010;
    localparam logic [2:0] OP_WRLO   = 3'b011;
    localparam logic [2:0] OP_WRFULL = 3'b100;
    localparam logic [2:0] OP_SHINS  = 3'b101;
    localparam logic [2:0] OP_CLR    = 3'b110;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             left_q, left_d;
    logic             done_q, done_d;

    function automatic logic [WIDTH-1:0] rot_one(input logic [WIDTH-1:0] v, input logic left);
        return left ? {v[WIDTH-CHUNK-1:0], v[WIDTH-1:WIDTH-CHUNK]}
                    : {v[CHUNK-1:0], v[WIDTH-1:CHUNK]};
    endfunction

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    done_d = 1'b1;
                    case (cmd_op_i)
                        OP_ROTL, OP_ROTR: begin
                            // Amount zero completes like a NOP; otherwise the accept edge is step one.
                            if (cmd_amt_i != '0) begin
                                left_d = (cmd_op_i == OP_ROTL);
                                data_d = rot_one(data_q, cmd_op_i == OP_ROTL);
                                cnt_d  = cmd_amt_i - AW'(1);
                                if (cmd_amt_i != AW'(1)) begin
                                    state_d = ROTATE;
                                    done_d  = 1'b0;
                                end
                            end
                        end
                        OP_WRLO:   data_d = {data_q[WIDTH-1:CHUNK], data_i[CHUNK-1:0]};
                        OP_WRFULL: data_d = data_i;
                        OP_SHINS:  data_d = {data_q[WIDTH-CHUNK-1:0], data_i[CHUNK-1:0]};
                        OP_CLR:    data_d = '0;
                        default:   ;
                    endcase
                end
            end
            ROTATE: begin
                data_d = rot_one(data_q, left_q);
                cnt_d  = cnt_q - AW'(1);
                if (cnt_q == AW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples the same pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            done_q  <= done_d;
        end
    end

    assign data_o      = data_q;
    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q == ROTATE);
    assign done_o      = done_q;

endmodule

// File: doc/chunk_rotate_register.md
CHUNK_ROTATE_REGISTER -- requirements
Module: chunk_rotate_register

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  WIDTH, 64, register width in bits.
  CHUNK, 16, rotate/write granularity in bits.
  NCH, WIDTH/CHUNK (derived), chunk count; a power of 2, at least 2.
  AW, clog2(NCH) (derived), amount field width.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk_i  in  1  sole clock, rising edge.
  rst_i  in  1  reset, asynchronous, active-high.
  cmd_valid_i  in  1  command present.
  cmd_ready_o  out  1  block can accept a command.
  cmd_op_i  in  3  operation code.
  cmd_amt_i  in  AW  rotate amount in chunks.
  data_i  in  WIDTH  write data.
  data_o  out  WIDTH  current register contents.
  busy_o  out  1  multi-cycle rotate in progress.
  done_o  out  1  one-cycle completion pulse.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-004 A command SHALL be accepted on a rising clk_i edge where cmd_valid_i=1, cmd_ready_o=1 and rst_i=0.
REQ-005 cmd_ready_o SHALL equal (state==IDLE).
REQ-006 busy_o SHALL equal (state==ROTATE).
REQ-007 Opcodes SHALL be as follows; all other codes behave as 000:
  000: NOP.
  001: ROTL, rotate left by cmd_amt_i chunks.
  010: ROTR, rotate right by cmd_amt_i chunks.
  011: WRLO, replace the low CHUNK bits with data_i[CHUNK-1:0].
  100: WRFULL, load all of data_i.
  101: SHINS, shift left one chunk and insert data_i[CHUNK-1:0] at the bottom.
  110: CLR, clear to zero.
REQ-008 Single-cycle ops (NOP, WRLO, WRFULL, SHINS, CLR) SHALL update the register at the accept edge and leave state in IDLE.
REQ-009 ROTL/ROTR with amt N>=1 SHALL rotate exactly one chunk per edge, with the first step on the accept edge, for N edges total.
  - Remaining count is loaded with N-1 at accept.
  - State goes to ROTATE if N-1 > 0, otherwise stays IDLE.
  - Each ROTATE edge performs one step and decrements the count.
  - The edge that performs the last step returns state to IDLE.
REQ-010 A rotate with N=0 SHALL leave the register unchanged and complete as a single-cycle op.
REQ-011 Rotate direction and count SHALL be latched at accept; cmd_op_i, cmd_amt_i, data_i and cmd_valid_i SHALL be ignored while in ROTATE.
REQ-012 done_o SHALL be registered and high for exactly the one cycle following the edge that completes any accepted command, NOP included.
REQ-013 A new command MAY be accepted in the same cycle done_o is high, giving back-to-back throughput of one single-cycle op per clock.
REQ-014 data_o SHALL be driven directly from the register, with no combinational path from inputs.
REQ-015 Rotation SHALL wrap modulo WIDTH: ROTL by N SHALL equal ROTR by NCH-N.

Reset
REQ-016 While rst_i=1, the block SHALL hold data_o=0, state=IDLE, remaining count=0, done_o=0 and busy_o=0; cmd_ready_o=1, but no command is accepted.
REQ-017 Assertion of rst_i during ROTATE SHALL abort the rotate immediately with no done_o pulse; the first accept is possible on the first edge after deassertion.

Verification (WIDTH=64, CHUNK=16)
REQ-018 The bench SHALL cover the following directed scenarios:
  - WRFULL 0x0123456789ABCDEF, then ROTL 1 -> data_o=0x456789ABCDEF0123 after 1 edge; done_o high 1 cycle; busy_o never high.
  - From 0x0123456789ABCDEF, ROTL 3 -> busy_o high 2 cycles, cmd_ready_o low 2 cycles; final value 0xCDEF0123456789AB; ROTR 1 from the same start gives the same value.
  - WRLO data_i=0x...BEEF on 0x0123456789ABCDEF -> 0x0123456789ABBEEF; then SHINS 0x1111 on the next edge -> 0x456789ABBEEF1111; two done_o pulses on consecutive cycles.
  - ROTL amt=0 -> value unchanged; done_o pulses once; busy_o stays 0.
  - During ROTL 3, change cmd_op_i/data_i and assert cmd_valid_i -> no effect; the next command is accepted in the done_o cycle.
  - Assert rst_i mid-ROTL 3 -> data_o=0 and busy_o=0 asynchronously; no done_o; after deassertion, WRFULL 0xFFFF000000000000 -> data_o=0xFFFF000000000000.
